// File: rtl/dff_bank_rr_arbiter_pkg.sv
// Shared definitions for the round-robin load arbiter.
//   - FSM state encoding (idle / owned)
//   - width helpers used to size index and counter fields
package dff_bank_rr_arbiter_pkg;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StOwned = 1'b1;

  // Width of an index able to address n items; never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a counter able to hold the value max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dff_bank_rr_arbiter_rr_pick.sv
// Combinational circular priority picker.
// Ports:
//   req_i  - request vector, bit i = requester i
//   ptr_i  - index where the circular scan starts
//   gnt_o  - one-hot winner (zero when no request)
//   idx_o  - winner index (zero when no request)
//   any_o  - at least one request present
module dff_bank_rr_arbiter_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  int unsigned cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/dff_bank_rr_arbiter.sv
// Round-robin arbiter and load sequencer for one shared W-bit register.
// Ports:
//   clk, reset - single clock, synchronous active-high reset
//   req_in     - per-requester request levels
//   data_in    - packed data, slice [i*W +: W] belongs to requester i
//   grant_out  - registered one-hot grant, zero when idle
//   owner_out  - current owner index, holds last owner when idle
//   q_out      - shared register contents
//   valid_out  - one-cycle pulse after each register load
module dff_bank_rr_arbiter
  import dff_bank_rr_arbiter_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N-1:0]                req_in,
  input  logic [N*W-1:0]              data_in,
  output logic [N-1:0]                grant_out,
  output logic [idx_width(N)-1:0]     owner_out,
  output logic [W-1:0]                q_out,
  output logic                        valid_out
);

  localparam int unsigned IdxW  = idx_width(N);
  localparam int unsigned HoldW = cnt_width(MAX_HOLD);

  logic [0:0]      state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [W-1:0]    reg_q, reg_d;
  logic            valid_q, valid_d;

  logic [IdxW-1:0] owner_inc;
  logic [IdxW-1:0] pick_ptr;
  logic [N-1:0]    pick_gnt;
  logic [IdxW-1:0] pick_idx;
  logic            pick_any;
  logic            own_req;
  logic            others;
  logic            hold_max;

  assign owner_inc = (int'(owner_q) == N - 1) ? '0 : owner_q + IdxW'(1);
  assign own_req   = |(req_in & grant_q);
  assign others    = |(req_in & ~grant_q);
  assign hold_max  = (hold_q == HoldW'(MAX_HOLD));

  // Idle arbitration scans from ptr; handover scans from owner+1, which is
  // also the pointer value committed on that edge.
  assign pick_ptr = (state_q == StIdle) ? ptr_q : owner_inc;

  dff_bank_rr_arbiter_rr_pick #(
    .N    (N),
    .IdxW (IdxW)
  ) u_pick (
    .req_i (req_in),
    .ptr_i (pick_ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    reg_d   = reg_q;
    valid_d = 1'b0;
    if (state_q == StIdle) begin
      if (pick_any) begin
        state_d = StOwned;
        grant_d = pick_gnt;
        owner_d = pick_idx;
        hold_d  = HoldW'(1);
      end
    end else begin
      if (own_req) begin
        reg_d   = data_in[int'(owner_q)*W +: W];
        valid_d = 1'b1;
      end
      if (!own_req || (hold_max && others)) begin
        ptr_d = owner_inc;
        if (others) begin
          grant_d = pick_gnt;
          owner_d = pick_idx;
          hold_d  = HoldW'(1);
        end else begin
          grant_d = '0;
          state_d = StIdle;
        end
      end else if (!hold_max) begin
        hold_d = hold_q + HoldW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      reg_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      reg_q   <= reg_d;
      valid_q <= valid_d;
    end
  end

  assign grant_out = grant_q;
  assign owner_out = owner_q;
  assign q_out     = reg_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_dff_bank_rr_arbiter.sv
// Self-checking bench for dff_bank_rr_arbiter (N=4, W=8, MAX_HOLD=4):
// directed scenarios followed by random traffic, all compared against an
// integer-level reference model of the arbitration rules.
module tb_dff_bank_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_in;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   grant_out;
  logic [1:0]     owner_out;
  logic [W-1:0]   q_out;
  logic           valid_out;

  int tests;
  int fails;
  int pulses;

  // Reference model state
  int       m_owner;   // -1 when idle
  int       m_last;    // owner index reported on owner_out
  int       m_ptr;
  int       m_hold;
  logic [7:0] m_q;
  bit       m_valid;

  dff_bank_rr_arbiter #(
    .N        (N),
    .W        (W),
    .MAX_HOLD (MH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_in    (req_in),
    .data_in   (data_in),
    .grant_out (grant_out),
    .owner_out (owner_out),
    .q_out     (q_out),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rst, input logic [N-1:0] r, input logic [N*W-1:0] d);
    bit own;
    bit oth;
    if (rst) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_hold = 0; m_q = 0; m_valid = 0;
    end else if (m_owner < 0) begin
      m_valid = 0;
      if (r != 0) begin
        m_owner = pick(r, m_ptr); m_last = m_owner; m_hold = 1;
      end
    end else begin
      own = r[m_owner];
      oth = (r & ~(N'(1) << m_owner)) != 0;
      m_valid = own;
      if (own) m_q = d[m_owner*W +: W];
      if (!own || (oth && m_hold == MH)) begin
        m_ptr = (m_owner + 1) % N;
        if (oth) begin
          m_owner = pick(r, m_ptr); m_last = m_owner; m_hold = 1;
        end else begin
          m_owner = -1;
        end
      end else if (m_hold < MH) begin
        m_hold++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model on the same edge, compare #1 later.
  task automatic step(input logic rst, input logic [N-1:0] r, input logic [N*W-1:0] d);
    logic [N-1:0] eg;
    reset = rst; req_in = r; data_in = d;
    @(posedge clk);
    model_step(rst, r, d);
    #1;
    eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    check("grant", 32'(grant_out), 32'(eg));
    check("owner", 32'(owner_out), 32'(m_last));
    check("q", 32'(q_out), 32'(m_q));
    check("valid", 32'(valid_out), 32'(m_valid));
    if (valid_out) pulses++;
  endtask

  function automatic logic [N*W-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [N*W-1:0] d;
    tests = 0; fails = 0; pulses = 0;
    reset = 1'b1; req_in = '0; data_in = '0;
    m_owner = -1; m_last = 0; m_ptr = 0; m_hold = 0; m_q = 0; m_valid = 0;
    step(1'b1, '0, '0);
    check("reset_grant", 32'(grant_out), 32'h0);

    // Reset mid-grant, then re-grant to requester 0
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0001, rnd_data());
    step(1'b1, 4'b0001, rnd_data());
    check("t1_grant", 32'(grant_out), 32'h0);
    check("t1_q", 32'(q_out), 32'h0);
    check("t1_valid", 32'(valid_out), 32'h0);
    step(1'b0, 4'b0001, rnd_data());
    check("t1_regrant", 32'(grant_out), 32'h1);

    // Single request latency
    step(1'b1, '0, '0);
    d = rnd_data(); d[2*W +: W] = 8'hA5;
    step(1'b0, 4'b0100, d);
    check("t2_grant", 32'(grant_out), 32'h4);
    check("t2_owner", 32'(owner_out), 32'd2);
    step(1'b0, 4'b0100, d);
    check("t2_q", 32'(q_out), 32'hA5);
    check("t2_valid", 32'(valid_out), 32'h1);

    // Release handover with no idle bubble
    step(1'b1, '0, '0);
    step(1'b0, 4'b0011, rnd_data());
    step(1'b0, 4'b0011, rnd_data());
    step(1'b0, 4'b0011, rnd_data());
    step(1'b0, 4'b0010, rnd_data());
    check("t3_handover", 32'(grant_out), 32'h2);
    d = rnd_data(); d[W +: W] = 8'h3C;
    step(1'b0, 4'b0010, d);
    check("t3_q", 32'(q_out), 32'h3C);

    // Forced rotation with all requesting
    step(1'b1, '0, '0);
    step(1'b0, 4'b1111, rnd_data());
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'b1111, rnd_data());
      if (i == 3) check("t4_rot1", 32'(grant_out), 32'h2);
      if (i == 11) check("t4_rot3", 32'(grant_out), 32'h8);
    end
    check("t4_pulses", 32'(pulses), 32'd16);
    check("t4_wrap", 32'(grant_out), 32'h1);

    // Sole requester saturation
    step(1'b1, '0, '0);
    step(1'b0, 4'b1000, rnd_data());
    pulses = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 4'b1000, rnd_data());
    check("t5_pulses", 32'(pulses), 32'd10);
    check("t5_grant", 32'(grant_out), 32'h8);
    // Hold count is saturated, so a new competitor preempts at once
    step(1'b0, 4'b1001, rnd_data());
    check("t5_preempt", 32'(grant_out), 32'h1);

    // Pointer wrap on release by requester 3
    step(1'b1, '0, '0);
    step(1'b0, 4'b1000, rnd_data());
    step(1'b0, 4'b0011, rnd_data());
    check("t6_wrap", 32'(grant_out), 32'h1);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), N'($urandom), rnd_data());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
